// File: rtl/pkt_pkg.sv
// Shared constants, word layout and FSM states for the receive packet parser.
// The optional trailing checksum word is enabled by RX_PKT_CHECKSUM_EN.
package pkt_pkg;

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CH   = 3'b001;
    localparam logic [2:0] PKT_TS   = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;

    localparam logic [2:0] HB_WORDS       = 3'd6;
    localparam logic [2:0] CH_WORDS       = 3'd3;
    localparam logic [2:0] TS_WORDS       = 3'd4;
    localparam logic [2:0] DATA_HDR_WORDS = 3'd3;

    localparam logic [2:0] IDX_SRC  = 3'd1;
    localparam logic [2:0] IDX_DEST = 3'd2;
    localparam logic [2:0] IDX_HOPS = 3'd2;
    localparam logic [2:0] IDX_EMAX = 3'd3;
    localparam logic [2:0] IDX_EMIN = 3'd4;
    localparam logic [2:0] IDX_ETHR = 3'd5;
    localparam logic [2:0] IDX_CH   = 3'd2;
    localparam logic [2:0] IDX_TS   = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_DRAIN,
        S_COMMIT
    } state_e;

    function automatic logic is_supported(input logic [2:0] t);
        return (t == PKT_HB) || (t == PKT_CH) ||
               (t == PKT_TS) || (t == PKT_DATA);
    endfunction

    // Index of the final word; DATA never ends inside the body walk.
    function automatic logic [2:0] last_idx(input logic [2:0] t,
                                            input logic       ck);
        logic [2:0] r;
        r = 3'd7;
        case (t)
            PKT_HB:  r = HB_WORDS - 3'd1 + {2'b00, ck};
            PKT_CH:  r = CH_WORDS - 3'd1 + {2'b00, ck};
            PKT_TS:  r = TS_WORDS - 3'd1 + {2'b00, ck};
            default: r = 3'd7;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rx_pkt_chk.sv
// Running XOR of packet words; o_match flags that the current word
// equals the XOR of all preceding words of the packet.
module rx_pkt_chk (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_sop,
    input  logic [15:0] i_data,
    output logic        o_match
);

    logic [15:0] r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 16'h0000;
        end else if (i_en) begin
            r_acc <= i_sop ? i_data : (r_acc ^ i_data);
        end
    end

    assign o_match = (r_acc == i_data);

endmodule

// File: rtl/rx_pkt_parser.sv
// Receive packet parser feeding the node-info block.
// Define RX_PKT_CHECKSUM_EN to require a trailing XOR checksum word.
module rx_pkt_parser
    import pkt_pkg::*;
#(
    parameter logic [15:0] MY_NODE_ID     = 16'h000C,
    parameter int          DATA_MAX_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_last,
    output logic        rx_ready,
    output logic        en_MNI,
    output logic [2:0]  fPktType,
    output logic [15:0] hops,
    output logic [15:0] e_max,
    output logic [15:0] e_min,
    output logic [15:0] e_threshold,
    output logic [15:0] ch_ID,
    output logic [15:0] timeslot,
    output logic        pkt_err
);

`ifdef RX_PKT_CHECKSUM_EN
    localparam logic CK = 1'b1;
`else
    localparam logic CK = 1'b0;
`endif

    state_e      r_state, w_nstate;
    logic        r_rdy;
    logic [2:0]  r_type, w_ntype;
    logic [2:0]  r_cnt, w_ncnt;
    logic        r_dmode, w_ndmode;
    logic        r_pend, w_npend;
    logic [6:0]  r_pay, w_npay;
    logic [15:0] r_sh_hops, r_sh_emax, r_sh_emin;
    logic [15:0] r_sh_ethr, r_sh_ch, r_sh_ts;
    logic        w_xfer, w_ck_ok, w_err, w_commit, w_rej;
    logic [2:0]  w_lidx;
    logic [7:0]  w_paylen;
    logic [15:0] w_hops_in, w_emax_in, w_emin_in;
    logic [15:0] w_ethr_in, w_ch_in, w_ts_in;

    assign rx_ready = r_rdy && (r_state != S_COMMIT);
    assign w_xfer   = rx_valid && rx_ready;
    assign w_lidx   = last_idx(r_type, CK);
    assign w_paylen = {1'b0, r_pay} + {7'd0, ~CK};

    assign w_rej = ((r_cnt == IDX_SRC) && (rx_data == MY_NODE_ID)) ||
                   ((r_cnt == IDX_DEST) &&
                    ((r_type == PKT_TS) || (r_type == PKT_DATA)) &&
                    (rx_data != MY_NODE_ID));

`ifdef RX_PKT_CHECKSUM_EN
    rx_pkt_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_xfer),
        .i_sop   (rx_sop),
        .i_data  (rx_data),
        .o_match (w_ck_ok)
    );
`else
    assign w_ck_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b0;
            r_type  <= 3'd0;
            r_cnt   <= 3'd0;
            r_dmode <= 1'b0;
            r_pend  <= 1'b0;
            r_pay   <= 7'd0;
        end else begin
            r_state <= w_nstate;
            r_rdy   <= 1'b1;
            r_type  <= w_ntype;
            r_cnt   <= w_ncnt;
            r_dmode <= w_ndmode;
            r_pend  <= w_npend;
            r_pay   <= w_npay;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ntype  = r_type;
        w_ncnt   = r_cnt;
        w_ndmode = r_dmode;
        w_npend  = r_pend;
        w_npay   = r_pay;
        w_err    = 1'b0;
        w_commit = 1'b0;
        if (r_state == S_COMMIT) begin
            w_nstate = S_IDLE;
        end else if (w_xfer && rx_sop) begin
            // A start word always opens a new packet, aborting any open one.
            w_err    = (r_state != S_IDLE) ||
                       (is_supported(rx_data[15:13]) && rx_last);
            w_ntype  = rx_data[15:13];
            w_ncnt   = 3'd1;
            w_ndmode = 1'b0;
            w_npend  = 1'b0;
            w_npay   = 7'd0;
            if (rx_last) begin
                w_nstate = S_IDLE;
            end else if (is_supported(rx_data[15:13])) begin
                w_nstate = S_BODY;
            end else begin
                w_nstate = S_DRAIN;
            end
        end else if (w_xfer && (r_state == S_BODY)) begin
            w_ncnt = r_cnt + 3'd1;
            if (rx_last && (r_cnt != w_lidx)) begin
                w_err    = 1'b1;
                w_nstate = S_IDLE;
            end else if (w_rej) begin
                w_nstate = S_DRAIN;
            end else if ((r_type == PKT_DATA) &&
                         (r_cnt == DATA_HDR_WORDS - 3'd1)) begin
                w_nstate = S_DRAIN;
                w_ndmode = 1'b1;
            end else if (r_cnt == w_lidx) begin
                if (!rx_last) begin
                    w_nstate = S_DRAIN;
                    w_npend  = 1'b1;
                end else if (w_ck_ok) begin
                    w_commit = 1'b1;
                    w_nstate = S_COMMIT;
                end else begin
                    w_err    = 1'b1;
                    w_nstate = S_IDLE;
                end
            end
        end else if (w_xfer && (r_state == S_DRAIN)) begin
            // r_pend marks an over-long packet: flag it on the extra word.
            w_err   = r_pend;
            w_npend = 1'b0;
            if (r_dmode && (r_pay != 7'h7F)) begin
                w_npay = r_pay + 7'd1;
            end
            if (rx_last) begin
                w_nstate = S_IDLE;
                if (r_dmode) begin
                    if ((w_paylen == 8'd0) || !w_ck_ok ||
                        (w_paylen > 8'(DATA_MAX_WORDS))) begin
                        w_err = 1'b1;
                    end else begin
                        w_commit = 1'b1;
                        w_nstate = S_COMMIT;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_hops <= 16'h0000;
            r_sh_emax <= 16'h0000;
            r_sh_emin <= 16'h0000;
            r_sh_ethr <= 16'h0000;
            r_sh_ch   <= 16'h0000;
            r_sh_ts   <= 16'h0000;
        end else if (w_xfer && !rx_sop && (r_state == S_BODY)) begin
            if (r_type == PKT_HB) begin
                if (r_cnt == IDX_HOPS) r_sh_hops <= rx_data;
                if (r_cnt == IDX_EMAX) r_sh_emax <= rx_data;
                if (r_cnt == IDX_EMIN) r_sh_emin <= rx_data;
                if (r_cnt == IDX_ETHR) r_sh_ethr <= rx_data;
            end
            if ((r_type == PKT_CH) && (r_cnt == IDX_CH)) r_sh_ch <= rx_data;
            if ((r_type == PKT_TS) && (r_cnt == IDX_TS)) r_sh_ts <= rx_data;
        end
    end

    // A field carried in the final word is taken straight from the bus.
    assign w_hops_in = (r_cnt == IDX_HOPS) ? rx_data : r_sh_hops;
    assign w_emax_in = (r_cnt == IDX_EMAX) ? rx_data : r_sh_emax;
    assign w_emin_in = (r_cnt == IDX_EMIN) ? rx_data : r_sh_emin;
    assign w_ethr_in = (r_cnt == IDX_ETHR) ? rx_data : r_sh_ethr;
    assign w_ch_in   = (r_cnt == IDX_CH)   ? rx_data : r_sh_ch;
    assign w_ts_in   = (r_cnt == IDX_TS)   ? rx_data : r_sh_ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_MNI      <= 1'b0;
            pkt_err     <= 1'b0;
            fPktType    <= 3'd0;
            hops        <= 16'h0000;
            e_max       <= 16'h0000;
            e_min       <= 16'h0000;
            e_threshold <= 16'h0000;
            ch_ID       <= 16'h0000;
            timeslot    <= 16'h0000;
        end else begin
            en_MNI  <= w_commit;
            pkt_err <= w_err;
            if (w_commit) begin
                fPktType <= r_type;
                case (r_type)
                    PKT_HB: begin
                        hops <= (w_hops_in == 16'hFFFF) ? 16'hFFFF :
                                (w_hops_in + 16'd1);
                        e_max       <= w_emax_in;
                        e_min       <= w_emin_in;
                        e_threshold <= w_ethr_in;
                    end
                    PKT_CH:  ch_ID    <= w_ch_in;
                    PKT_TS:  timeslot <= w_ts_in;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_pkt_parser.sv
// Self-checking bench for rx_pkt_parser: directed plan plus random packets
// scored against a whole-packet reference model.
module tb_rx_pkt_parser;

    localparam logic [15:0] ME   = 16'h000C;
    localparam int          MAXW = 16;
`ifdef RX_PKT_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] rx_data;
    logic        rx_valid, rx_sop, rx_last, rx_ready;
    logic        en_MNI, pkt_err;
    logic [2:0]  fPktType;
    logic [15:0] hops, e_max, e_min, e_threshold, ch_ID, timeslot;

    rx_pkt_parser dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sop      (rx_sop),
        .rx_last     (rx_last),
        .rx_ready    (rx_ready),
        .en_MNI      (en_MNI),
        .fPktType    (fPktType),
        .hops        (hops),
        .e_max       (e_max),
        .e_min       (e_min),
        .e_threshold (e_threshold),
        .ch_ID       (ch_ID),
        .timeslot    (timeslot),
        .pkt_err     (pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tot_en  = 0;
    int tot_err = 0;

    always @(negedge clk) begin
        if (en_MNI === 1'b1) tot_en++;
        if (pkt_err === 1'b1) tot_err++;
    end

    logic [2:0]  e_type;
    logic [15:0] e_hops, e_emax, e_emin, e_thr, e_ch, e_ts;
    logic [15:0] pq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_word(input logic [15:0] d, input logic s,
                              input logic l);
        int w;
        w = 0;
        rx_data  = d;
        rx_sop   = s;
        rx_last  = l;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (rx_ready !== 1'b1) chk("ready_timeout", {31'd0, rx_ready}, 1);
        else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic check_fields(input string tag);
        chk({tag, "_type"}, {29'd0, fPktType}, {29'd0, e_type});
        chk({tag, "_hops"}, {16'd0, hops}, {16'd0, e_hops});
        chk({tag, "_emax"}, {16'd0, e_max}, {16'd0, e_emax});
        chk({tag, "_emin"}, {16'd0, e_min}, {16'd0, e_emin});
        chk({tag, "_ethr"}, {16'd0, e_threshold}, {16'd0, e_thr});
        chk({tag, "_ch"}, {16'd0, ch_ID}, {16'd0, e_ch});
        chk({tag, "_ts"}, {16'd0, timeslot}, {16'd0, e_ts});
    endtask

    // 0 = silent drop, 1 = commit, 2 = error; judged on the whole packet.
    function automatic int classify();
        int          n;
        int          pay;
        int          base;
        logic [2:0]  t;
        logic [15:0] x;
        bit          ck_ok;
        n = pq.size();
        t = pq[0][15:13];
        if (!(t == 3'd0 || t == 3'd1 || t == 3'd4 || t == 3'd5)) return 0;
        if (n <= 2) return 2;
        if (pq[1] == ME) return 0;
        if (t == 3'd4 || t == 3'd5) begin
            if (n == 3) return 2;
            if (pq[2] != ME) return 0;
        end
        ck_ok = 1'b1;
        if (CK == 1) begin
            x = 16'h0000;
            for (int i = 0; i < n - 1; i++) x ^= pq[i];
            ck_ok = (x == pq[n-1]);
        end
        if (t == 3'd5) begin
            pay = n - 3 - CK;
            if (pay < 1 || pay > MAXW || !ck_ok) return 2;
            return 1;
        end
        base = (t == 3'd0) ? 6 : (t == 3'd1) ? 3 : 4;
        if (n != base + CK || !ck_ok) return 2;
        return 1;
    endfunction

    task automatic apply_commit();
        logic [2:0] t;
        t = pq[0][15:13];
        e_type = t;
        if (t == 3'd0) begin
            e_hops = (pq[2] == 16'hFFFF) ? 16'hFFFF : pq[2] + 16'd1;
            e_emax = pq[3];
            e_emin = pq[4];
            e_thr  = pq[5];
        end
        if (t == 3'd1) e_ch = pq[2];
        if (t == 3'd4) e_ts = pq[3];
    endtask

    task automatic add_ck(input bit bad);
        logic [15:0] x;
        x = 16'h0000;
        foreach (pq[i]) x ^= pq[i];
        if (bad) x ^= 16'h0100;
        if (CK == 1) pq.push_back(x);
    endtask

    task automatic run_pkt(input string tag, input bit bad_ck);
        int out, en0, er0;
        add_ck(bad_ck);
        out = classify();
        en0 = tot_en;
        er0 = tot_err;
        for (int i = 0; i < pq.size(); i++)
            drive_word(pq[i], i == 0, i == pq.size() - 1);
        chk({tag, "_en_edge"}, {31'd0, en_MNI}, {31'd0, out == 1});
        if (out == 1) begin
            chk({tag, "_bubble"}, {31'd0, rx_ready}, 0);
            apply_commit();
        end
        idle(3);
        chk({tag, "_n_en"}, tot_en - en0, (out == 1) ? 1 : 0);
        chk({tag, "_n_err"}, tot_err - er0, (out == 2) ? 1 : 0);
        check_fields(tag);
    endtask

    task automatic gen_rand();
        int          t, n, base, r;
        logic [15:0] w;
        t = $urandom_range(0, 7);
        pq.delete();
        pq.push_back({3'(t), 13'($urandom)});
        if (t == 5) begin
            r = $urandom_range(0, 9);
            n = 3 + ((r == 0) ? 0 : (r == 1) ? MAXW + 1 :
                     $urandom_range(1, MAXW));
        end else if (t == 0 || t == 1 || t == 4) begin
            base = (t == 0) ? 6 : (t == 1) ? 3 : 4;
            n = base;
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(1, 2);
                n = $urandom_range(0, 1) ? base + r : base - r;
            end
        end else begin
            n = $urandom_range(1, 6);
        end
        for (int i = 1; i < n; i++) begin
            w = 16'($urandom);
            if (i == 1) begin
                r = $urandom_range(0, 7);
                w = (r == 0) ? ME : (r == 1) ? 16'h0003 : w;
            end
            if (i == 2 && (t == 4 || t == 5))
                w = ($urandom_range(0, 4) == 0) ? 16'h0007 : ME;
            if (i == 2 && t == 0 && $urandom_range(0, 3) == 0)
                w = 16'hFFFF;
            pq.push_back(w);
        end
    endtask

    int en0, er0;

    initial begin
        rst = 1'b1;
        rx_data = 16'h0000;
        rx_valid = 1'b0;
        rx_sop = 1'b0;
        rx_last = 1'b0;
        {e_type, e_hops, e_emax, e_emin, e_thr, e_ch, e_ts} = '0;
        idle(3);
        chk("rst_ready", {31'd0, rx_ready}, 0);
        chk("rst_en", {31'd0, en_MNI}, 0);
        chk("rst_err", {31'd0, pkt_err}, 0);
        check_fields("rst");
        rst = 1'b0;
        chk("rst_rel_ready", {31'd0, rx_ready}, 0);
        idle(1);
        chk("ready_up", {31'd0, rx_ready}, 1);

        pq = '{16'h1ABC, 16'h0003, 16'h0002, 16'h0FA0, 16'h0100, 16'h0200};
        run_pkt("hb1", 1'b0);
        pq = '{16'h2000, 16'h0003, 16'h000C};
        run_pkt("ch1", 1'b0);
        pq = '{16'h8000, 16'h0003, 16'h000C, 16'h0005};
        run_pkt("ts1", 1'b0);
        pq = '{16'h8000, 16'h0003, 16'h0007, 16'h0009};
        run_pkt("ts_dest", 1'b0);
        pq = '{16'h0000, 16'h000C, 16'h0004, 16'h1, 16'h2, 16'h3};
        run_pkt("hb_echo", 1'b0);
        pq = '{16'h2000, 16'h0003};
        run_pkt("ch_short", 1'b0);
        pq = '{16'h0000, 16'h0003, 16'hFFFF, 16'h0011, 16'h0022, 16'h0033};
        run_pkt("hb_sat", 1'b0);
        pq = '{16'h4000, 16'h0003, 16'h0001};
        run_pkt("unsup", 1'b0);

        pq = '{16'hA000, 16'h0003, 16'h000C, 16'h5555};
        run_pkt("data1", 1'b0);
        pq = '{16'hA000, 16'h0003, 16'h000C};
        for (int i = 0; i < MAXW; i++) pq.push_back(16'(i));
        run_pkt("data_max", 1'b0);
        pq = '{16'hA000, 16'h0003, 16'h000C};
        for (int i = 0; i <= MAXW; i++) pq.push_back(16'(i));
        run_pkt("data_long", 1'b0);
        pq = '{16'hA000, 16'h0003, 16'h000C};
        run_pkt("data_zero", 1'b0);

        en0 = tot_en;
        er0 = tot_err;
        drive_word(16'h0000, 1'b1, 1'b0);
        drive_word(16'h0003, 1'b0, 1'b0);
        drive_word(16'h0077, 1'b0, 1'b0);
        drive_word(16'h0088, 1'b0, 1'b0);
        pq = '{16'h2000, 16'h0005, 16'h0ABC};
        add_ck(1'b0);
        for (int i = 0; i < pq.size(); i++)
            drive_word(pq[i], i == 0, i == pq.size() - 1);
        apply_commit();
        idle(3);
        chk("abort_n_err", tot_err - er0, 1);
        chk("abort_n_en", tot_en - en0, 1);
        check_fields("abort");

`ifdef RX_PKT_CHECKSUM_EN
        pq = '{16'h2000, 16'h0003, 16'h0042};
        run_pkt("ck_good", 1'b0);
        pq = '{16'h2000, 16'h0003, 16'h0043};
        run_pkt("ck_bad", 1'b1);
`endif

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 5) == 0)
                drive_word(16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            gen_rand();
            run_pkt("rnd", $urandom_range(0, 5) == 0);
        end

        en0 = tot_en;
        er0 = tot_err;
        drive_word(16'h0000, 1'b1, 1'b0);
        drive_word(16'h0003, 1'b0, 1'b0);
        drive_word(16'h0009, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, rx_ready}, 0);
        {e_type, e_hops, e_emax, e_emin, e_thr, e_ch, e_ts} = '0;
        idle(2);
        rst = 1'b0;
        idle(3);
        chk("mid_rst_n_en", tot_en - en0, 0);
        chk("mid_rst_n_err", tot_err - er0, 0);
        chk("mid_rst_ready_up", {31'd0, rx_ready}, 1);
        check_fields("mid_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
